display_controller: RTL and testbench



---
 rtl/display_controller.sv | 177 +++++++++++++++++
 tb/tb_display_controller.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_controller.sv
// Avalon-MM register slave driving six 7-segment digit codes with
// hardware blink and scroll.
//
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   avs_address         - word address (0..7)
//   avs_read/avs_write  - single-cycle strobes, no waitrequest
//   avs_writedata       - 32-bit write data
//   avs_readdata        - read data, valid the cycle after avs_read
//   display_0..5        - registered digit codes to display_driver k
//   display_blank       - bit k = 1 blanks digit k
//
// Register map:
//   0 DIGITS  RW  [23:0] nibble k = source digit k
//   1 CONTROL RW  [5:0] enable, [8] blink_en, [9] scroll_en, [10] scroll_dir
//   2 PERIOD  RW  clk cycles per tick (0 behaves as 1)
//   3 STATUS  RO  [0] phase, [3:1] offset
//   4 COMMAND WO  bit0 clear DIGITS, bit1 restart timer
module display_controller #(
    parameter int PERIOD_WIDTH   = 32,
    parameter int DEFAULT_PERIOD = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic [3:0]  display_5,
    output logic [3:0]  display_4,
    output logic [3:0]  display_3,
    output logic [3:0]  display_2,
    output logic [3:0]  display_1,
    output logic [3:0]  display_0,
    output logic [5:0]  display_blank
);

    localparam logic [PERIOD_WIDTH-1:0] PERIOD_RST =
        PERIOD_WIDTH'(DEFAULT_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0] ONE = PERIOD_WIDTH'(1);

    logic [23:0]             digits;
    logic [5:0]              enable;
    logic                    blink_en;
    logic                    scroll_en;
    logic                    scroll_dir;
    logic [PERIOD_WIDTH-1:0] period;
    logic [PERIOD_WIDTH-1:0] counter;
    logic                    phase;
    logic [2:0]              offset;

    logic [3:0]  disp_q [6];
    logic [3:0]  disp_d [6];
    logic [5:0]  blank_d;
    logic [31:0] rd_mux;

    logic                    wr_digits;
    logic                    wr_control;
    logic                    wr_period;
    logic                    wr_command;
    logic                    cmd_clear;
    logic                    cmd_restart;
    logic [PERIOD_WIDTH-1:0] last_count;
    logic                    tick;
    logic [2:0]              offset_next;

    assign wr_digits   = avs_write && (avs_address == 3'd0);
    assign wr_control  = avs_write && (avs_address == 3'd1);
    assign wr_period   = avs_write && (avs_address == 3'd2);
    assign wr_command  = avs_write && (avs_address == 3'd4);
    assign cmd_clear   = wr_command && avs_writedata[0];
    assign cmd_restart = wr_command && avs_writedata[1];

    // A PERIOD of zero is treated as one, so the counter always wraps at 0.
    assign last_count = (period == '0) ? '0 : period - ONE;
    assign tick       = (counter >= last_count);

    always_comb begin
        offset_next = offset;
        if (scroll_dir)
            offset_next = (offset == 3'd0) ? 3'd5 : offset - 3'd1;
        else
            offset_next = (offset == 3'd5) ? 3'd0 : offset + 3'd1;
    end

    // Digit k shows source nibble (k + offset) mod 6.
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            int idx;
            idx = k + int'(offset);
            if (idx >= 6)
                idx = idx - 6;
            disp_d[k] = digits[4*idx +: 4];
        end
        blank_d = ~enable | {6{blink_en & phase}};
    end

    always_comb begin
        rd_mux = '0;
        unique case (avs_address)
            3'd0: rd_mux[23:0] = digits;
            3'd1: rd_mux[10:0] = {scroll_dir, scroll_en, blink_en,
                                  2'b00, enable};
            3'd2: rd_mux[PERIOD_WIDTH-1:0] = period;
            3'd3: rd_mux[3:0] = {offset, phase};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digits        <= '0;
            enable        <= 6'h3F;
            blink_en      <= 1'b0;
            scroll_en     <= 1'b0;
            scroll_dir    <= 1'b0;
            period        <= PERIOD_RST;
            counter       <= '0;
            phase         <= 1'b0;
            offset        <= '0;
            avs_readdata  <= '0;
            display_blank <= '0;
            for (int k = 0; k < 6; k++)
                disp_q[k] <= '0;
        end else begin
            if (wr_digits)
                digits <= avs_writedata[23:0];
            else if (cmd_clear)
                digits <= '0;

            if (wr_control) begin
                enable     <= avs_writedata[5:0];
                blink_en   <= avs_writedata[8];
                scroll_en  <= avs_writedata[9];
                scroll_dir <= avs_writedata[10];
            end

            if (wr_period)
                period <= avs_writedata[PERIOD_WIDTH-1:0];

            // Restart overrides both a PERIOD write and a coincident tick.
            if (cmd_restart) begin
                counter <= '0;
                phase   <= 1'b0;
                offset  <= '0;
            end else begin
                if (wr_period || tick)
                    counter <= '0;
                else
                    counter <= counter + ONE;
                if (tick) begin
                    phase <= ~phase;
                    if (scroll_en)
                        offset <= offset_next;
                end
            end

            // Read mux samples pre-write state, so a same-cycle write
            // to the read address returns the old value.
            if (avs_read)
                avs_readdata <= rd_mux;

            display_blank <= blank_d;
            for (int k = 0; k < 6; k++)
                disp_q[k] <= disp_d[k];
        end
    end

    assign display_0 = disp_q[0];
    assign display_1 = disp_q[1];
    assign display_2 = disp_q[2];
    assign display_3 = disp_q[3];
    assign display_4 = disp_q[4];
    assign display_5 = disp_q[5];

endmodule

// File: tb/tb_display_controller.sv
// Self-checking bench for display_controller: register table, directed
// timer/scroll/blink sequences and randomized traffic against a model.
module tb_display_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic [3:0]  display_5, display_4, display_3;
    logic [3:0]  display_2, display_1, display_0;
    logic [5:0]  display_blank;

    int total = 0;
    int bad   = 0;

    display_controller dut (
        .clk          (clk),
        .reset        (reset),
        .avs_address  (avs_address),
        .avs_read     (avs_read),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata (avs_readdata),
        .display_5    (display_5),
        .display_4    (display_4),
        .display_3    (display_3),
        .display_2    (display_2),
        .display_1    (display_1),
        .display_0    (display_0),
        .display_blank(display_blank)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [23:0] m_dig;
    logic [31:0] m_ctrl;
    logic [31:0] m_per;
    logic [31:0] m_cnt;
    logic        m_ph;
    int          m_off;
    logic [31:0] e_rd;
    logic [23:0] e_disp;
    logic [5:0]  e_blank;

    function automatic logic [23:0] disp_bus();
        return {display_5, display_4, display_3,
                display_2, display_1, display_0};
    endfunction

    function automatic bit m_tick();
        logic [31:0] lim;
        lim = (m_per == 0) ? 32'd1 : m_per;
        return m_cnt >= lim - 1;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return {8'h0, m_dig};
            3'd1: return m_ctrl;
            3'd2: return m_per;
            3'd3: return {28'h0, 3'(m_off), m_ph};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_dig   = 0;
        m_ctrl  = 32'h3F;
        m_per   = 32'd25000000;
        m_cnt   = 0;
        m_ph    = 0;
        m_off   = 0;
        e_rd    = 0;
        e_disp  = 0;
        e_blank = 0;
    endtask

    task automatic model_edge(input bit rst, input bit rd, input bit wr,
                              input logic [2:0] a, input logic [31:0] wd);
        logic [31:0] ncnt;
        logic        nph;
        int          noff;
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 6; k++)
            e_disp[4*k +: 4] = m_dig[4*((k + m_off) % 6) +: 4];
        e_blank = ~m_ctrl[5:0] | ((m_ctrl[8] && m_ph) ? 6'h3F : 6'h0);
        if (rd)
            e_rd = m_read(a);
        ncnt = m_tick() ? 0 : m_cnt + 1;
        nph  = m_ph;
        noff = m_off;
        if (m_tick()) begin
            nph = ~m_ph;
            if (m_ctrl[9])
                noff = m_ctrl[10] ? (m_off + 5) % 6 : (m_off + 1) % 6;
        end
        if (wr) begin
            case (a)
                3'd0: m_dig = wd[23:0];
                3'd1: m_ctrl = wd & 32'h73F;
                3'd2: begin
                    m_per = wd;
                    ncnt  = 0;
                end
                3'd4: begin
                    if (wd[0])
                        m_dig = 0;
                    if (wd[1]) begin
                        ncnt = 0;
                        nph  = 0;
                        noff = 0;
                    end
                end
                default: ;
            endcase
        end
        m_cnt = ncnt;
        m_ph  = nph;
        m_off = noff;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit rd, input bit wr,
                        input logic [2:0] a, input logic [31:0] wd);
        reset         = rst;
        avs_read      = rd;
        avs_write     = wr;
        avs_address   = a;
        avs_writedata = wd;
        @(posedge clk);
        model_edge(rst, rd, wr, a, wd);
        #1;
        chk("model_readdata", avs_readdata, e_rd);
        chk("model_display", {8'h0, disp_bus()}, {8'h0, e_disp});
        chk("model_blank", {26'h0, display_blank}, {26'h0, e_blank});
        reset     = 0;
        avs_read  = 0;
        avs_write = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 3'd0, 32'h0);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
        step(0, 0, 1, a, wd);
    endtask

    task automatic rd_reg(input string nm, input logic [2:0] a,
                          input logic [31:0] exp);
        step(0, 1, 0, a, 32'h0);
        chk(nm, avs_readdata, exp);
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [2:0]  a;
        logic [31:0] wd;
        bit          chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[$];

    initial begin
        reset         = 1;
        avs_read      = 0;
        avs_write     = 0;
        avs_address   = 0;
        avs_writedata = 0;
        model_reset();

        step(1, 0, 0, 3'd0, 32'h0);
        step(1, 0, 0, 3'd0, 32'h0);
        chk("reset_display", {8'h0, disp_bus()}, 32'h0);
        chk("reset_blank", {26'h0, display_blank}, 32'h0);
        chk("reset_readdata", avs_readdata, 32'h0);

        tbl.push_back('{1, 0, 3'd0, 32'h0, 1, 32'h0});
        tbl.push_back('{1, 0, 3'd1, 32'h0, 1, 32'h3F});
        tbl.push_back('{1, 0, 3'd2, 32'h0, 1, 32'd25000000});
        tbl.push_back('{1, 0, 3'd3, 32'h0, 1, 32'h0});
        tbl.push_back('{0, 1, 3'd0, 32'h00543210, 0, 32'h0});
        tbl.push_back('{0, 1, 3'd1, 32'h3F, 0, 32'h0});
        tbl.push_back('{1, 0, 3'd0, 32'h0, 1, 32'h00543210});
        tbl.push_back('{1, 0, 3'd5, 32'h0, 1, 32'h0});
        tbl.push_back('{1, 0, 3'd4, 32'h0, 1, 32'h0});
        tbl.push_back('{0, 1, 3'd5, 32'hDEADBEEF, 0, 32'h0});
        tbl.push_back('{1, 0, 3'd5, 32'h0, 1, 32'h0});
        tbl.push_back('{0, 1, 3'd3, 32'hF, 0, 32'h0});
        tbl.push_back('{1, 0, 3'd3, 32'h0, 1, 32'h0});
        tbl.push_back('{1, 0, 3'd7, 32'h0, 1, 32'h0});
        tbl.push_back('{1, 1, 3'd0, 32'hFFABCDEF, 1, 32'h00543210});
        tbl.push_back('{1, 0, 3'd0, 32'h0, 1, 32'h00ABCDEF});
        tbl.push_back('{0, 1, 3'd1, 32'hFFFFFFFF, 0, 32'h0});
        tbl.push_back('{1, 0, 3'd1, 32'h0, 1, 32'h73F});
        tbl.push_back('{0, 1, 3'd1, 32'h3F, 0, 32'h0});
        tbl.push_back('{0, 1, 3'd0, 32'h00543210, 0, 32'h0});
        tbl.push_back('{0, 0, 3'd0, 32'h0, 0, 32'h0});

        foreach (tbl[i]) begin
            step(0, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd);
            if (tbl[i].chk_rd)
                chk($sformatf("table_rd%0d", i), avs_readdata,
                    tbl[i].exp_rd);
        end
        chk("digits_shown", {8'h0, disp_bus()}, 32'h00543210);
        chk("all_lit", {26'h0, display_blank}, 32'h0);

        // Blink with PERIOD=4
        wr_reg(3'd2, 32'd4);
        wr_reg(3'd4, 32'h2);
        wr_reg(3'd1, 32'h13F);
        idle(3);
        chk("blink_off", {26'h0, display_blank}, 32'h0);
        idle(1);
        chk("blink_on", {26'h0, display_blank}, 32'h3F);
        idle(3);
        chk("blink_still_on", {26'h0, display_blank}, 32'h3F);
        idle(1);
        chk("blink_off_again", {26'h0, display_blank}, 32'h0);
        idle(8);

        // Scroll left with PERIOD=2
        wr_reg(3'd0, 32'h00543210);
        wr_reg(3'd2, 32'd2);
        wr_reg(3'd1, 32'h23F);
        wr_reg(3'd4, 32'h2);
        idle(3);
        chk("scroll_l_d0", {28'h0, display_0}, 32'h1);
        chk("scroll_l_d5", {28'h0, display_5}, 32'h0);
        idle(10);
        chk("scroll_wrap_d0", {28'h0, display_0}, 32'h0);

        // Scroll right
        wr_reg(3'd1, 32'h63F);
        wr_reg(3'd4, 32'h2);
        idle(3);
        chk("scroll_r_d0", {28'h0, display_0}, 32'h5);
        idle(5);

        // Restart on the tick cycle, PERIOD=3
        wr_reg(3'd1, 32'h3F);
        wr_reg(3'd2, 32'd3);
        idle(2);
        wr_reg(3'd4, 32'h2);
        rd_reg("restart_status", 3'd3, 32'h0);
        idle(1);
        rd_reg("pre_tick_status", 3'd3, 32'h0);
        rd_reg("post_tick_status", 3'd3, 32'h1);

        // Clear digits
        wr_reg(3'd4, 32'h1);
        idle(1);
        chk("clear_display", {8'h0, disp_bus()}, 32'h0);
        rd_reg("clear_digits", 3'd0, 32'h0);

        // Reset mid-scroll with blink
        wr_reg(3'd0, 32'h00987654);
        wr_reg(3'd2, 32'd2);
        wr_reg(3'd1, 32'h31E);
        idle(7);
        step(1, 1, 0, 3'd0, 32'h0);
        chk("midrst_display", {8'h0, disp_bus()}, 32'h0);
        chk("midrst_blank", {26'h0, display_blank}, 32'h0);
        chk("midrst_rd", avs_readdata, 32'h0);
        rd_reg("midrst_ctrl", 3'd1, 32'h3F);
        rd_reg("midrst_per", 3'd2, 32'd25000000);
        rd_reg("midrst_status", 3'd3, 32'h0);

        // Randomized traffic
        wr_reg(3'd2, 32'd3);
        for (int n = 0; n < 4000; n++) begin
            bit          rst, rd, wr;
            logic [2:0]  a;
            logic [31:0] wd;
            rst = ($urandom_range(0, 299) == 0);
            rd  = $urandom_range(0, 2) == 0;
            wr  = $urandom_range(0, 3) == 0;
            a   = 3'($urandom_range(0, 7));
            wd  = $urandom;
            if (a == 3'd2) begin
                wd = $urandom_range(0, 5);
                if (m_tick())
                    wr = 0;
            end
            if (a == 3'd4 && $urandom_range(0, 3) != 0)
                wd = 0;
            step(rst, rd, wr, a, wd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
